// File: rtl/busca_instrucao.sv
// Instruction fetch stage: latches PC, fetches over req/ack, holds word for decode.
// Optional fetch timeout enabled by defining BUSCA_TIMEOUT_EN.
module busca_instrucao #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] end_instrucao,
  input  logic                  flush,
  output logic                  cp_enable,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instrucao,
  output logic [ADDR_WIDTH-1:0] instr_end,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  erro_busca
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ESPERA = 2'd1,
    CHEIO  = 2'd2
  } estado_t;

  estado_t               r_state;
  estado_t               w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nx;
  logic                  r_desc;
  logic                  w_desc_nx;
  logic                  w_load;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_iend;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("busca_instrucao: TIMEOUT must be 1..255");
  end

`ifdef BUSCA_TIMEOUT_EN
  localparam logic [7:0] LIM = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;
  logic       r_erro;

  // Timeout fires on the last allowed ESPERA cycle with no ack.
  assign w_timeout = (r_state == ESPERA) && !mem_ack
                     && (r_cnt == LIM);

  // Count ESPERA cycles; zero outside ESPERA so entry starts fresh.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state != ESPERA || w_next != ESPERA) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Sticky error flag, only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_erro <= 1'b0;
    end else if (w_timeout) begin
      r_erro <= 1'b1;
    end
  end

  assign erro_busca = r_erro;
`else
  assign w_timeout  = 1'b0;
  assign erro_busca = 1'b0;
`endif

  // Next-state, handshake outputs and PC enable.
  always_comb begin
    w_next    = r_state;
    w_addr_nx = r_addr;
    w_desc_nx = r_desc;
    w_load    = 1'b0;
    mem_req   = 1'b0;
    cp_enable = flush;
    unique case (r_state)
      OCIOSO: begin
        if (!flush) begin
          w_addr_nx = end_instrucao;
          w_next    = ESPERA;
        end
      end
      ESPERA: begin
        mem_req   = 1'b1;
        cp_enable = flush | (mem_ack & ~r_desc);
        if (mem_ack) begin
          if (r_desc || flush) begin
            w_desc_nx = 1'b0;
            w_next    = OCIOSO;
          end else begin
            w_load = 1'b1;
            w_next = CHEIO;
          end
        end else if (w_timeout) begin
          w_desc_nx = 1'b0;
          w_next    = OCIOSO;
        end else if (flush) begin
          w_desc_nx = 1'b1;
        end
      end
      CHEIO: begin
        if (flush) begin
          w_next = OCIOSO;
        end else if (instr_ready) begin
          w_addr_nx = end_instrucao;
          w_next    = ESPERA;
        end
      end
      default: begin
        w_next    = OCIOSO;
        w_desc_nx = 1'b0;
      end
    endcase
  end

  // Control state: FSM, request address and discard flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= OCIOSO;
      r_addr  <= '0;
      r_desc  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_addr  <= w_addr_nx;
      r_desc  <= w_desc_nx;
    end
  end

  // Hold the accepted word and its address for decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instr <= '0;
      r_iend  <= '0;
    end else if (w_load) begin
      r_instr <= mem_data;
      r_iend  <= r_addr;
    end
  end

  assign mem_addr    = r_addr;
  assign instrucao   = r_instr;
  assign instr_end   = r_iend;
  assign instr_valid = (r_state == CHEIO);

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao with a simple PC model.
// Timeout expectations follow BUSCA_TIMEOUT_EN.
module tb_busca_instrucao;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef BUSCA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic [AW-1:0] target;
  logic          flush;
  logic          cp_enable;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          ack;
  logic [DW-1:0] data;
  logic [DW-1:0] instrucao;
  logic [AW-1:0] instr_end;
  logic          instr_valid;
  logic          ready;
  logic          erro_busca;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  busca_instrucao #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .end_instrucao(pc),
    .flush        (flush),
    .cp_enable    (cp_enable),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (ack),
    .mem_data     (data),
    .instrucao    (instrucao),
    .instr_end    (instr_end),
    .instr_valid  (instr_valid),
    .instr_ready  (ready),
    .erro_busca   (erro_busca)
  );

  // PC unit model: load target on flush, else increment when enabled.
  always @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else if (cp_enable) pc <= flush ? target : pc + 1'b1;
  end

  task automatic do_reset;
    reset = 1'b1; flush = 1'b0; ack = 1'b0;
    ready = 1'b0; data = '0; target = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; ack = 1'b1;
    ready = 1'b1; data = 32'hFFFF_FFFF; target = '0;
    @(negedge clk); #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b exp 0", mem_req); end
    n_cmp++; if (mem_addr !== '0) begin n_bad++; $display("FAIL rst_addr got %h exp 0", mem_addr); end
    n_cmp++; if (instrucao !== '0) begin n_bad++; $display("FAIL rst_instr got %h exp 0", instrucao); end
    n_cmp++; if (instr_end !== '0) begin n_bad++; $display("FAIL rst_iend got %h exp 0", instr_end); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    n_cmp++; if (cp_enable !== 1'b0) begin n_bad++; $display("FAIL rst_cpen got %b exp 0", cp_enable); end
    n_cmp++; if (erro_busca !== 1'b0) begin n_bad++; $display("FAIL rst_erro got %b exp 0", erro_busca); end
  endtask

  task automatic test_stream;
    int k = 0;
    int j = 0;
    int cyc = 0;
    do_reset;
    ready = 1'b1;
    while (cyc < 20 && j < 4) begin
      @(negedge clk);
      cyc++;
      ack  = mem_req;
      data = 32'hA000_0000 + 32'(mem_addr);
      #1;
      if (mem_req) begin
        n_cmp++; if (mem_addr !== AW'(k)) begin n_bad++; $display("FAIL seq_addr got %h exp %h", mem_addr, AW'(k)); end
        n_cmp++; if (cp_enable !== 1'b1) begin n_bad++; $display("FAIL seq_cpen_ack got %b exp 1", cp_enable); end
        k++;
      end else begin
        n_cmp++; if (cp_enable !== 1'b0) begin n_bad++; $display("FAIL seq_cpen_idle got %b exp 0", cp_enable); end
      end
      if (instr_valid) begin
        n_cmp++; if (instrucao !== 32'hA000_0000 + 32'(j)) begin n_bad++; $display("FAIL seq_instr got %h exp %h", instrucao, 32'hA000_0000 + 32'(j)); end
        n_cmp++; if (instr_end !== AW'(j)) begin n_bad++; $display("FAIL seq_iend got %h exp %h", instr_end, AW'(j)); end
        j++;
      end
    end
    n_cmp++; if (j !== 4) begin n_bad++; $display("FAIL seq_count got %0d exp 4", j); end
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL seq_rate got %0d cycles exp 8", cyc); end
  endtask

  task automatic test_slow_and_stall;
    do_reset;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      ack  = (i == 5);
      data = 32'hDEAD_BEEF;
      #1;
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL slow_req c%0d got %b exp 1", i, mem_req); end
      n_cmp++; if (mem_addr !== '0) begin n_bad++; $display("FAIL slow_addr c%0d got %h exp 0", i, mem_addr); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL slow_valid c%0d got %b exp 0", i, instr_valid); end
      n_cmp++; if (cp_enable !== (i == 5)) begin n_bad++; $display("FAIL slow_cpen c%0d got %b exp %b", i, cp_enable, i == 5); end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ack  = 1'b1;
      data = 32'h1234_5678;
      #1;
      n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid c%0d got %b exp 1", i, instr_valid); end
      n_cmp++; if (instrucao !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL stall_instr c%0d got %h exp deadbeef", i, instrucao); end
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req c%0d got %b exp 0", i, mem_req); end
      n_cmp++; if (cp_enable !== 1'b0) begin n_bad++; $display("FAIL stall_cpen c%0d got %b exp 0", i, cp_enable); end
    end
    @(negedge clk);
    ack = 1'b0; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0; #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== AW'(1)) begin n_bad++; $display("FAIL stall_next got req %b addr %h exp 1 0001", mem_req, mem_addr); end
  endtask

  task automatic test_flush_espera;
    do_reset;
    @(negedge clk);
    flush = 1'b1; target = AW'('h0123); #1;
    n_cmp++; if (cp_enable !== 1'b1) begin n_bad++; $display("FAIL fle_cpen got %b exp 1", cp_enable); end
    @(negedge clk);
    flush = 1'b0; #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== '0) begin n_bad++; $display("FAIL fle_hold got req %b addr %h exp 1 0000", mem_req, mem_addr); end
    @(negedge clk);
    ack = 1'b1; data = 32'hBAD0_0000; #1;
    n_cmp++; if (cp_enable !== 1'b0) begin n_bad++; $display("FAIL fle_drop_cpen got %b exp 0", cp_enable); end
    @(negedge clk);
    ack = 1'b0; #1;
    n_cmp++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL fle_bubble got valid %b req %b exp 0 0", instr_valid, mem_req); end
    @(negedge clk); #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== AW'('h0123)) begin n_bad++; $display("FAIL fle_target got req %b addr %h exp 1 0123", mem_req, mem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL fle_valid got %b exp 0", instr_valid); end
  endtask

  task automatic test_flush_ack_cheio;
    do_reset;
    @(negedge clk);
    ack = 1'b1; flush = 1'b1; target = AW'('h0200); data = 32'hBAD1_0000; #1;
    n_cmp++; if (cp_enable !== 1'b1) begin n_bad++; $display("FAIL fa_cpen got %b exp 1", cp_enable); end
    @(negedge clk);
    ack = 1'b0; flush = 1'b0; #1;
    n_cmp++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || cp_enable !== 1'b0) begin n_bad++; $display("FAIL fa_bubble got valid %b req %b cpen %b exp 0 0 0", instr_valid, mem_req, cp_enable); end
    @(negedge clk);
    ack = 1'b1; data = 32'hC0DE_0200; ready = 1'b1; #1;
    n_cmp++; if (mem_addr !== AW'('h0200)) begin n_bad++; $display("FAIL fa_target got %h exp 0200", mem_addr); end
    @(negedge clk);
    ack = 1'b0; flush = 1'b1; target = AW'('h0300); #1;
    n_cmp++; if (instr_valid !== 1'b1 || instrucao !== 32'hC0DE_0200 || instr_end !== AW'('h0200)) begin n_bad++; $display("FAIL fc_word got %b %h %h exp 1 c0de0200 0200", instr_valid, instrucao, instr_end); end
    n_cmp++; if (cp_enable !== 1'b1) begin n_bad++; $display("FAIL fc_cpen got %b exp 1", cp_enable); end
    @(negedge clk);
    flush = 1'b0; ready = 1'b0; #1;
    n_cmp++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL fc_drop got valid %b req %b exp 0 0", instr_valid, mem_req); end
    @(negedge clk); #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== AW'('h0300)) begin n_bad++; $display("FAIL fc_target got req %b addr %h exp 1 0300", mem_req, mem_addr); end
  endtask

  task automatic test_reset_midfetch;
    do_reset;
    @(negedge clk);
    reset = 1'b1; #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL mid_req got %b exp 0", mem_req); end
    @(negedge clk);
    reset = 1'b0; ack = 1'b1; data = 32'hBAD2_0000; #1;
    n_cmp++; if (cp_enable !== 1'b0) begin n_bad++; $display("FAIL mid_ack_ign got %b exp 0", cp_enable); end
    @(negedge clk);
    ack = 1'b0; #1;
    n_cmp++; if (instr_valid !== 1'b0 || mem_req !== 1'b1) begin n_bad++; $display("FAIL mid_refetch got valid %b req %b exp 0 1", instr_valid, mem_req); end
  endtask

  task automatic test_timeout;
    logic exp_req;
    logic exp_err;
    do_reset;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      exp_req = TO_EN ? (k != TO + 1) : 1'b1;
      exp_err = TO_EN ? (k > TO) : 1'b0;
      n_cmp++; if (mem_req !== exp_req) begin n_bad++; $display("FAIL to_req c%0d got %b exp %b", k, mem_req, exp_req); end
      n_cmp++; if (erro_busca !== exp_err) begin n_bad++; $display("FAIL to_err c%0d got %b exp %b", k, erro_busca, exp_err); end
      n_cmp++; if (mem_addr !== '0 || cp_enable !== 1'b0) begin n_bad++; $display("FAIL to_retry c%0d got addr %h cpen %b exp 0000 0", k, mem_addr, cp_enable); end
    end
    do_reset; #1;
    n_cmp++; if (erro_busca !== 1'b0) begin n_bad++; $display("FAIL to_clear got %b exp 0", erro_busca); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_slow_and_stall;
    test_flush_espera;
    test_flush_ack_cheio;
    test_reset_midfetch;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
